// File: rtl/frog_sprite_renderer.sv
// frog_sprite_renderer: beam position -> 2-bit frog sprite code with a frame-latched position, 2-clock aligned pipeline.
// Optional FROG_MIRROR_EN adds frog_face_left for horizontal mirroring; sprite contents come from ROM_INIT (entry i at bits [2i+1:2i], row-major).
module frog_sprite_renderer #(
   parameter int SPRITE_W = 16,
   parameter int SPRITE_H = 16,
   parameter int V_VISIBLE = 480,
   parameter logic [1:0] TRANSPARENT_CODE = 2'b11,
   parameter logic [2*SPRITE_W*SPRITE_H-1:0] ROM_INIT = '0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] h_count,
   input  logic [9:0] v_count,
   input  logic       video_on_in,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic [9:0] frog_x,
   input  logic [9:0] frog_y,
   input  logic       frog_show,
`ifdef FROG_MIRROR_EN
   input  logic       frog_face_left,
`endif
   output logic [1:0] sprite_pixel,
   output logic       sprite_active,
   output logic       video_on_out,
   output logic       hsync_out,
   output logic       vsync_out
);
   localparam int XW = $clog2(SPRITE_W);
   localparam int YW = $clog2(SPRITE_H);
   localparam int AW = XW + YW;

   logic [9:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic          show_q, show_d, face_q, face_d, latch;
   logic [XW-1:0] rel_x, col;
   logic [YW-1:0] rel_y;
   logic [AW-1:0] addr_q, addr_d;
   logic          in_box_q, in_box_d, act_q, act_d;
   logic [2:0]    flags1_q, flags1_d, flags2_q, flags2_d;
   logic [1:0]    pix_q, pix_d, rom_data;

   always_comb begin
      latch   = (h_count == 10'd0) && (v_count == 10'(V_VISIBLE));
      pos_x_d = latch ? frog_x : pos_x_q;
      pos_y_d = latch ? frog_y : pos_y_q;
      show_d  = latch ? frog_show : show_q;
`ifdef FROG_MIRROR_EN
      face_d  = latch ? frog_face_left : face_q;
`else
      face_d  = 1'b0;
`endif
      rel_x    = XW'(h_count) - XW'(pos_x_q);
      rel_y    = YW'(v_count) - YW'(pos_y_q);
      col      = face_q ? XW'(SPRITE_W - 1) - rel_x : rel_x;
      addr_d   = {rel_y, col};
      // 11-bit compares so a sprite near column/line 1023 clips rather than wrapping to 0
      in_box_d = show_q & video_on_in
               & ({1'b0, h_count} >= {1'b0, pos_x_q})
               & ({1'b0, h_count} <  {1'b0, pos_x_q} + 11'(SPRITE_W))
               & ({1'b0, v_count} >= {1'b0, pos_y_q})
               & ({1'b0, v_count} <  {1'b0, pos_y_q} + 11'(SPRITE_H));
      flags1_d = {video_on_in, hsync_in, vsync_in};
      rom_data = ROM_INIT[{addr_q, 1'b0} +: 2];
      pix_d    = in_box_q ? rom_data : 2'b00;
      act_d    = in_box_q & (rom_data != TRANSPARENT_CODE);
      flags2_d = flags1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_x_q  <= '0;
         pos_y_q  <= '0;
         show_q   <= 1'b0;
         face_q   <= 1'b0;
         addr_q   <= '0;
         in_box_q <= 1'b0;
         flags1_q <= '0;
         pix_q    <= '0;
         act_q    <= 1'b0;
         flags2_q <= '0;
      end else begin
         pos_x_q  <= pos_x_d;
         pos_y_q  <= pos_y_d;
         show_q   <= show_d;
         face_q   <= face_d;
         addr_q   <= addr_d;
         in_box_q <= in_box_d;
         flags1_q <= flags1_d;
         pix_q    <= pix_d;
         act_q    <= act_d;
         flags2_q <= flags2_d;
      end
   end

   assign sprite_pixel  = pix_q;
   assign sprite_active = act_q;
   assign {video_on_out, hsync_out, vsync_out} = flags2_q;
endmodule

// File: tb/tb_frog_sprite_renderer.sv
// tb_frog_sprite_renderer: directed beam vectors; expected outputs queued by the driver, checked by an independent monitor.
module tb_frog_sprite_renderer;
   typedef struct {
      int         due;
      int         h;
      int         v;
      logic [5:0] exp;
   } exp_t;

   function automatic logic [1:0] pat(input int i);
      return 2'(((i ^ (i >> 4)) + 3) % 4);
   endfunction

   function automatic logic [511:0] build_rom();
      logic [511:0] r;
      for (int i = 0; i < 256; i++) r[2*i +: 2] = pat(i);
      return r;
   endfunction

   localparam logic [511:0] ROM_BITS = build_rom();

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] h_count = '0, v_count = '0, frog_x = '0, frog_y = '0;
   logic       video_on_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, frog_show = 1'b0;
   logic       frog_face_left = 1'b0;
   logic [1:0] sprite_pixel;
   logic       sprite_active, video_on_out, hsync_out, vsync_out;

   int   ncyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   int   m_x = 0, m_y = 0;
   logic m_show = 1'b0, m_face = 1'b0;

   frog_sprite_renderer #(.ROM_INIT(ROM_BITS)) dut (
      .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
      .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .frog_x(frog_x), .frog_y(frog_y), .frog_show(frog_show),
`ifdef FROG_MIRROR_EN
      .frog_face_left(frog_face_left),
`endif
      .sprite_pixel(sprite_pixel), .sprite_active(sprite_active),
      .video_on_out(video_on_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ncyc <= ncyc + 1;

   function automatic logic [5:0] got();
      return {sprite_pixel, sprite_active, video_on_out, hsync_out, vsync_out};
   endfunction

   always @(negedge clk) begin
      if (q.size() > 0 && q[0].due <= ncyc) begin
         exp_t e;
         e = q.pop_front();
         n_cmp++;
         if (e.due != ncyc || got() !== e.exp) begin
            n_bad++;
            $display("FAIL beam(%0d,%0d): got pix/act/vid/hs/vs=%b required %b", e.h, e.v, got(), e.exp);
         end
      end
   end

   task automatic drive(input int h, input int v);
      exp_t e;
      logic vid, hs, vs, inb;
      int   rx, ry, addr;
      logic [1:0] code;
      @(negedge clk);
      vid = (h < 640) && (v < 480);
      hs  = (h >= 656) && (h < 752);
      vs  = (v >= 490) && (v < 492);
      h_count = 10'(h); v_count = 10'(v);
      video_on_in = vid; hsync_in = hs; vsync_in = vs;
      inb  = m_show && vid && h >= m_x && h < m_x + 16 && v >= m_y && v < m_y + 16;
      rx   = (h - m_x) & 15;
      ry   = (v - m_y) & 15;
      addr = ry * 16 + (m_face ? 15 - rx : rx);
      code = pat(addr);
      e.due = ncyc + 2; e.h = h; e.v = v;
      e.exp = {inb ? code : 2'b00, inb && code != 2'b11, vid, hs, vs};
      q.push_back(e);
      if (h == 0 && v == 480) begin
         m_x = int'(frog_x); m_y = int'(frog_y); m_show = frog_show; m_face = frog_face_left;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: %0d results outstanding, required 0", q.size());
         q.delete();
      end
   endtask

   task automatic check_zero(input string name);
      n_cmp++;
      if (got() !== 6'b0) begin
         n_bad++;
         $display("FAIL %s: got %b required 000000", name, got());
      end
   endtask

   initial begin
      #100000;
      n_bad++;
      $display("FAIL timeout: simulation did not complete, required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      frog_show = 1'b1; frog_x = 10'd100; frog_y = 10'd200;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         h_count = 10'(100 + i); v_count = 10'd200; video_on_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
         #1 check_zero("reset_hold");
      end
      @(negedge clk) rst_n = 1'b1;
      for (int h = 100; h < 104; h++) drive(h, 200);
      drive(0, 480);
      for (int h = 99; h < 118; h++) drive(h, 200);
      for (int h = 114; h < 117; h++) drive(h, 215);
      drive(100, 216);
      frog_x = 10'd300;
      drive(100, 250);
      drive(100, 205); drive(300, 205);
      drive(0, 480);
      drive(100, 205); drive(300, 205); drive(315, 210); drive(316, 210);
      frog_x = 10'd1020; frog_y = 10'd470;
      drive(0, 480);
      for (int v = 470; v < 474; v++) for (int h = 1020; h < 1024; h++) drive(h, v);
      for (int h = 0; h < 4; h++) drive(h, 470);
      frog_x = 10'd630; frog_y = 10'd100;
      drive(0, 480);
      for (int h = 628; h < 642; h++) drive(h, 100);
      for (int h = 654; h < 659; h++) drive(h, 10);
      for (int h = 750; h < 753; h++) drive(h, 491);
      frog_x = 10'd0; frog_y = 10'd0;
      drive(0, 480);
      drive(0, 0); drive(15, 15); drive(16, 0);
`ifdef FROG_MIRROR_EN
      frog_face_left = 1'b1;
`endif
      frog_x = 10'd100; frog_y = 10'd200;
      drive(0, 480);
      drive(100, 200); drive(101, 200); drive(115, 203);
      drive(101, 200);
      drain();
      @(negedge clk) rst_n = 1'b0;
      #1 check_zero("reset_midframe");
      m_x = 0; m_y = 0; m_show = 1'b0; m_face = 1'b0;
      @(negedge clk) check_zero("reset_midframe_hold");
      rst_n = 1'b1;
      drive(101, 200); drive(100, 200);
      drive(0, 480);
      drive(101, 200); drive(100, 200);
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
